// File: rtl/eka_arb_pkg.sv
// Shared types and constants for the Eka memory arbiter.
package eka_arb_pkg;

    // Instruction sequencing: fetch, decode/execute, optional data access, commit.
    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_DATA,
        S_COMMIT
    } arb_state_t;

    localparam int unsigned PERF_W = 32;

endpackage

// File: rtl/eka_perf_counter.sv
// Free-running event counter with synchronous active-high clear; wraps modulo 2^WIDTH.
module eka_perf_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    // Next count: add one on each qualified event.
    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/eka_mem_arbiter.sv
// Shares one single-port memory bus between the Eka core's fetch and data ports.
// Each instruction runs fetch -> execute -> (data -> commit) so a single-cycle core
// works against a multi-cycle handshaked memory.
// Optional build macro EKA_ARB_PERF_EN adds retired/fetch-wait/data-wait counters.
module eka_mem_arbiter
    import eka_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [31:0]           data_addr,
    input  logic [31:0]           mem_wr_data,
    input  logic                  mem_wr,
    input  logic                  mem_rd,
    output logic [31:0]           instruction,
    output logic                  inst_valid,
    output logic                  data_stall,
    output logic [31:0]           mem_rd_data,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wdata,
    input  logic                  bus_ready,
    input  logic [31:0]           bus_rdata
`ifdef EKA_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0]     perf_retired,
    output logic [PERF_W-1:0]     perf_fetch_wait,
    output logic [PERF_W-1:0]     perf_data_wait
`endif
);

    arb_state_t  state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] data_q, data_d;
    logic        is_load;

    // A simultaneous load+store request is treated as a store.
    assign is_load = mem_rd & ~mem_wr;

    // Next-state and bus/core outputs; reset forces the idle output values immediately.
    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        data_d     = data_q;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = inst_addr;
        bus_wdata  = mem_wr_data;
        inst_valid = 1'b0;
        data_stall = 1'b1;

        case (state_q)
            S_FETCH: begin
                bus_req = 1'b1;
                if (bus_ready) begin
                    inst_d  = bus_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                inst_valid = 1'b1;
                if (mem_rd | mem_wr) begin
                    state_d = S_DATA;
                end else begin
                    // Commit cycle for instructions without a data access.
                    data_stall = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_DATA: begin
                bus_req    = 1'b1;
                bus_we     = mem_wr;
                bus_addr   = data_addr[ADDR_WIDTH-1:0];
                inst_valid = 1'b1;
                if (bus_ready) begin
                    if (is_load) begin
                        data_d = bus_rdata;
                    end
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                // Core still drives mem_wr here; the store is deliberately not reissued.
                inst_valid = 1'b1;
                data_stall = 1'b0;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (reset) begin
            bus_req    = 1'b0;
            bus_we     = 1'b0;
            inst_valid = 1'b0;
            data_stall = 1'b1;
        end
    end

    // State and capture registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            inst_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            data_q  <= data_d;
        end
    end

    // Latched values seen by the core read as zero while reset is held.
    assign instruction = reset ? 32'h0 : inst_q;
    assign mem_rd_data = reset ? 32'h0 : data_q;

`ifdef EKA_ARB_PERF_EN
    logic retire_ev, fetch_wait_ev, data_wait_ev;

    assign retire_ev     = inst_valid & ~data_stall;
    assign fetch_wait_ev = ~reset & (state_q == S_FETCH) & ~bus_ready;
    assign data_wait_ev  = ~reset & (state_q == S_DATA) & ~bus_ready;

    eka_perf_counter #(
        .WIDTH (PERF_W)
    ) u_perf_retired (
        .clk   (clk),
        .reset (reset),
        .inc   (retire_ev),
        .count (perf_retired)
    );

    eka_perf_counter #(
        .WIDTH (PERF_W)
    ) u_perf_fetch_wait (
        .clk   (clk),
        .reset (reset),
        .inc   (fetch_wait_ev),
        .count (perf_fetch_wait)
    );

    eka_perf_counter #(
        .WIDTH (PERF_W)
    ) u_perf_data_wait (
        .clk   (clk),
        .reset (reset),
        .inc   (data_wait_ev),
        .count (perf_data_wait)
    );
`endif

endmodule

// File: doc/eka_mem_arbiter.md
# eka_mem_arbiter

Shares one single-port memory bus between the Eka core's instruction-fetch and data-access ports, sequencing each instruction as fetch, then optional data access, then commit. It sits between the Eka core and the unified memory. It drives the core's `instruction`, `inst_valid`, `data_stall` and `mem_rd_data` inputs, so a single-cycle core runs correctly against a multi-cycle, handshaked memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of `inst_addr` and `bus_addr`.

Ports:
- `clk`  in  1  processor clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `inst_addr`  in  ADDR_WIDTH  fetch address from core.
- `data_addr`  in  32  data address from core.
- `mem_wr_data`  in  32  store data from core.
- `mem_wr`  in  1  core store request.
- `mem_rd`  in  1  core load request.
- `instruction`  out  32  latched instruction to core.
- `inst_valid`  out  1  `instruction` is valid.
- `data_stall`  out  1  hold core state.
- `mem_rd_data`  out  32  latched load data to core.
- `bus_req`  out  1  memory request; held until `bus_ready`.
- `bus_we`  out  1  write request, qualified by `bus_req`.
- `bus_addr`  out  ADDR_WIDTH  memory address.
- `bus_wdata`  out  32  memory write data.
- `bus_ready`  in  1  memory accepts/completes; may be high in the same cycle as `bus_req`.
- `bus_rdata`  in  32  read data, valid when `bus_req & bus_ready & !bus_we`.

## Operation
- States are S_FETCH, S_EXEC, S_DATA and S_COMMIT. The reset state is S_FETCH.
- **S_FETCH**
  - Outputs: `bus_req`=1, `bus_we`=0, `bus_addr`=`inst_addr`, `inst_valid`=0, `data_stall`=1.
  - When `bus_ready` is high, capture `bus_rdata` into `inst_q` and go to S_EXEC.
- **S_EXEC**
  - Outputs: `inst_valid`=1, `bus_req`=0.
  - If `mem_rd|mem_wr` (decoded by the core from `inst_q`): `data_stall`=1, go to S_DATA.
  - Otherwise: `data_stall`=0; this is the commit cycle, so the core writes back and advances PC. Go to S_FETCH.
- **S_DATA**
  - Outputs: `bus_req`=1, `bus_we`=`mem_wr`, `bus_addr`=`data_addr[ADDR_WIDTH-1:0]`, `bus_wdata`=`mem_wr_data`, `inst_valid`=1, `data_stall`=1.
  - When `bus_ready` is high: on a load, capture `bus_rdata` into `data_q`; go to S_COMMIT.
- **S_COMMIT**
  - Outputs: `inst_valid`=1, `data_stall`=0, `bus_req`=0. Go to S_FETCH.
  - The store is never reissued here, even though the core still drives `mem_wr`=1.
- Output sources:
  - `instruction` = `inst_q`.
  - `mem_rd_data` = `data_q`.
  - Both hold their values until overwritten.
- Exactly one commit cycle (`inst_valid & !data_stall`) occurs per instruction. Every store produces exactly one bus write.
- If `mem_rd` and `mem_wr` are both high, treat the access as a write.

## Timing
- Reset values, forced combinationally while `reset`=1:
  - `bus_req`=0, `bus_we`=0, `inst_valid`=0, `data_stall`=1.
  - `inst_q`=0, `data_q`=0, state S_FETCH.
- The first fetch request is issued in the first cycle with `reset`=0.
- Latency with zero-wait memory (`bus_ready` high in the request cycle):
  - ALU/branch instruction: 2 cycles (FETCH, EXEC).
  - Load/store: 4 cycles (FETCH, EXEC, DATA, COMMIT).
  - Each memory wait cycle adds 1 cycle in S_FETCH or S_DATA.
- While `bus_req` is high, `bus_addr`, `bus_we` and `bus_wdata` stay stable until `bus_ready` is seen.
- Reset mid-transaction: the request is abandoned in the same cycle (`bus_req` goes low). The memory must tolerate a dropped request; a write may or may not have taken effect.
- `bus_ready` while `bus_req`=0 is ignored.

## Configuration
- `EKA_ARB_PERF_EN` defined adds these outputs, all reset to 0:
  - `perf_retired` (32): increments on each commit cycle.
  - `perf_fetch_wait` (32): increments each S_FETCH cycle with `bus_ready`=0.
  - `perf_data_wait` (32): increments each S_DATA cycle with `bus_ready`=0.
- Counters wrap modulo 2^32.
- Without the macro, the ports and logic are absent and the behaviour above is unchanged.

## Structure
- Package `eka_arb_pkg` holds:
  - `typedef enum logic [1:0] arb_state_t {S_FETCH, S_EXEC, S_DATA, S_COMMIT}`.
  - `localparam PERF_W = 32`.
- Sub-module `eka_perf_counter` (WIDTH, `clk`, `reset`, `inc`, `count`) is instantiated three times, only under `EKA_ARB_PERF_EN`.

## Test plan
- Zero-wait memory, ADDI at address 0x0 with `inst_addr`=0x0 → `bus_req` in cycle 1, commit in cycle 2, next fetch from address 0x4 in cycle 3.
- Load of 0xDEADBEEF from 0x100 with 2 wait cycles on the data access → `data_stall` stays high through S_DATA. `mem_rd_data`=0xDEADBEEF in the commit cycle. Total 6 cycles.
- Store of 0x12345678 to 0x200 → exactly one bus write (`bus_we`=1, `bus_addr`=0x200), none in S_COMMIT; memory readback gives 0x12345678.
- Reset asserted in S_DATA with `bus_ready`=0 → same cycle `bus_req`=0, `inst_valid`=0. After release, fetch from the core's reset PC.
- `bus_ready` held low for 5 cycles in S_FETCH → `bus_addr` stable and `inst_valid`=0 throughout; no commit occurs.
- With `EKA_ARB_PERF_EN`: 3 ALU instructions plus 1 load with 1 fetch wait and 2 data waits → `perf_retired`=4, `perf_fetch_wait`=1, `perf_data_wait`=2.
